controlador_contador: RTL

Sequencing controller for the 4-bit display counter path. It replaces the free-running divided clock with a single-clock design: an internal prescaler produces a one-cycle count-enable pulse.
- A start/pause FSM owns the count value. It supports up/down direction, a programmable terminal value and one-shot or continuous mode.
- Output S drives the existing 7-segment decoder directly.

---
 rtl/controlador_contador_pkg.sv | 18 +
 rtl/controlador_contador_gerador_tick.sv | 56 +++++
 rtl/controlador_contador.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/controlador_contador_pkg.sv
// rtl/controlador_contador_pkg.sv - shared state encodings and defaults for the display counter controller
//
// Purpose: state encoding of the start/pause FSM and the default count width,
//          shared by controlador_contador and its bench.
// Ports:   none (package).

package controlador_contador_pkg;

    localparam int LARGURA_PADRAO = 4;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        FIM      = 2'b11
    } estado_t;

endpackage

// File: rtl/controlador_contador_gerador_tick.sv
// rtl/controlador_contador_gerador_tick.sv - prescaler producing a registered one-cycle count-enable pulse
//
// Purpose: counts 0..DIVISOR-1 while enabled and raises o_tick during the
//          cycle in which the count sits at DIVISOR-1 and the owner is
//          still enabled.
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_habilita      count this cycle (owner is in its counting state now)
//   i_habilita_prox owner will be in its counting state next cycle
//   i_limpa         clear the count (wins over i_habilita)
//   o_tick          registered pulse, high while count == DIVISOR-1 and enabled

module gerador_tick #(
    parameter int DIVISOR = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_habilita,
    input  logic i_habilita_prox,
    input  logic i_limpa,
    output logic o_tick
);

    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [W-1:0] MAXIMO = W'(DIVISOR - 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_prox;
    logic         r_tick;

    always_comb begin
        w_cnt_prox = r_cnt;
        if (i_limpa) begin
            w_cnt_prox = '0;
        end else if (i_habilita) begin
            w_cnt_prox = (r_cnt == MAXIMO) ? '0 : r_cnt + 1'b1;
        end
    end

    // The pulse is registered from the next count and next enable, so it is
    // high exactly in the cycles where the count equals DIVISOR-1 while the
    // owner is counting; a held count of DIVISOR-1 fires again on resume.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_prox;
            r_tick <= i_habilita_prox && (w_cnt_prox == MAXIMO);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/controlador_contador.sv
// rtl/controlador_contador.sv - start/pause sequencing controller for the 4-bit display counter
//
// Purpose: single-clock counter controller. An internal prescaler gives a
//          count-enable pulse; a start/pause FSM owns the count value, with
//          up/down direction, programmable terminal value and one-shot or
//          continuous operation. S feeds the 7-segment decoder directly.
// Ports:
//   clock_inicial  system clock
//   reset          asynchronous active-low reset
//   iniciar        start/restart request (async level, acted on at sync rising edge)
//   pausar         pause/resume request (async level, acted on at sync rising edge)
//   direcao        0 = up 0->limite, 1 = down limite->0 (latched at start)
//   continuo       0 = stop at target, 1 = wrap and keep counting (read live)
//   limite         terminal value (latched at start)
//   S              current count value
//   tick           one-cycle count-enable pulse, only while counting
//   estado         current FSM state
//   fim            one-cycle pulse when S reaches the target

module controlador_contador
    import controlador_contador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIVISOR = 50000000
) (
    input  logic               clock_inicial,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               direcao,
    input  logic               continuo,
    input  logic [LARGURA-1:0] limite,
    output logic [LARGURA-1:0] S,
    output logic               tick,
    output logic [1:0]         estado,
    output logic               fim
);

    // Synchronizers plus one history flop each for edge detection.
    logic r_ini_s1, r_ini_s2, r_ini_h;
    logic r_pau_s1, r_pau_s2, r_pau_h;
    logic w_ini_borda;
    logic w_pau_borda;

    estado_t r_estado;
    estado_t w_estado_prox;

    logic               r_dir;
    logic [LARGURA-1:0] r_lim;
    logic [LARGURA-1:0] r_s;
    logic               r_fim;

    logic               w_dir_prox;
    logic [LARGURA-1:0] w_lim_prox;
    logic [LARGURA-1:0] w_s_prox;
    logic               w_fim_prox;

    logic [LARGURA-1:0] w_inicio;
    logic [LARGURA-1:0] w_alvo;
    logic [LARGURA-1:0] w_inicio_novo;
    logic [LARGURA-1:0] w_passo;
    logic               w_tick;
    logic               w_avanca;

    always_ff @(posedge clock_inicial or negedge reset) begin
        if (!reset) begin
            r_ini_s1 <= 1'b0;
            r_ini_s2 <= 1'b0;
            r_ini_h  <= 1'b0;
            r_pau_s1 <= 1'b0;
            r_pau_s2 <= 1'b0;
            r_pau_h  <= 1'b0;
        end else begin
            r_ini_s1 <= iniciar;
            r_ini_s2 <= r_ini_s1;
            r_ini_h  <= r_ini_s2;
            r_pau_s1 <= pausar;
            r_pau_s2 <= r_pau_s1;
            r_pau_h  <= r_pau_s2;
        end
    end

    assign w_ini_borda = r_ini_s2 & ~r_ini_h;
    assign w_pau_borda = r_pau_s2 & ~r_pau_h;

    // Start and target of the run in progress (latched values) and of a
    // run being started this cycle (live inputs).
    assign w_inicio      = r_dir ? r_lim : '0;
    assign w_alvo        = r_dir ? '0 : r_lim;
    assign w_inicio_novo = direcao ? limite : '0;
    assign w_passo       = r_dir ? (r_s - 1'b1) : (r_s + 1'b1);

    // A pause edge discards a coincident tick; a start edge overrides both.
    assign w_avanca = (r_estado == CONTANDO) && w_tick && !w_pau_borda;

    // State register.
    always_ff @(posedge clock_inicial or negedge reset) begin
        if (!reset) begin
            r_estado <= PARADO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Next-state logic.
    always_comb begin
        w_estado_prox = r_estado;
        if (w_ini_borda) begin
            // limite=0 makes start equal target: a one-shot run is over at once.
            w_estado_prox = ((limite == '0) && !continuo) ? FIM : CONTANDO;
        end else begin
            case (r_estado)
                CONTANDO: begin
                    if (w_pau_borda) begin
                        w_estado_prox = PAUSADO;
                    end else if (w_tick) begin
                        if (r_s != w_alvo) begin
                            if ((w_passo == w_alvo) && !continuo) begin
                                w_estado_prox = FIM;
                            end
                        end else if ((w_inicio == w_alvo) && !continuo) begin
                            // Degenerate run: each reload is itself a target hit.
                            w_estado_prox = FIM;
                        end
                    end
                end
                PAUSADO: begin
                    if (w_pau_borda) begin
                        w_estado_prox = CONTANDO;
                    end
                end
                default: begin
                    w_estado_prox = r_estado;
                end
            endcase
        end
    end

    // Datapath next values: count, target pulse and latched run settings.
    always_comb begin
        w_dir_prox = r_dir;
        w_lim_prox = r_lim;
        w_s_prox   = r_s;
        w_fim_prox = 1'b0;
        if (w_ini_borda) begin
            w_dir_prox = direcao;
            w_lim_prox = limite;
            w_s_prox   = w_inicio_novo;
            w_fim_prox = (limite == '0);
        end else if (w_avanca) begin
            if (r_s != w_alvo) begin
                w_s_prox   = w_passo;
                w_fim_prox = (w_passo == w_alvo);
            end else begin
                // Sitting on target in continuous mode: wrap back to start.
                w_s_prox   = w_inicio;
                w_fim_prox = (w_inicio == w_alvo);
            end
        end
    end

    always_ff @(posedge clock_inicial or negedge reset) begin
        if (!reset) begin
            r_dir <= 1'b0;
            r_lim <= '0;
            r_s   <= '0;
            r_fim <= 1'b0;
        end else begin
            r_dir <= w_dir_prox;
            r_lim <= w_lim_prox;
            r_s   <= w_s_prox;
            r_fim <= w_fim_prox;
        end
    end

    // The prescaler runs in every cycle spent in CONTANDO (including the
    // cycle a pause is taken) and is held otherwise.
    gerador_tick #(
        .DIVISOR(DIVISOR)
    ) u_gerador_tick (
        .i_clk          (clock_inicial),
        .i_rst_n        (reset),
        .i_habilita     (r_estado == CONTANDO),
        .i_habilita_prox(w_estado_prox == CONTANDO),
        .i_limpa        (w_ini_borda),
        .o_tick         (w_tick)
    );

    assign S      = r_s;
    assign fim    = r_fim;
    assign estado = r_estado;
    assign tick   = w_tick;

endmodule
